mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the data memory in the multicycle datapath.
- Accepts one byte-addressed request at a time from the MEM stage: opcode, ALU-computed address, store data, size, signedness.
- Drives the word-indexed data memory port (MemR/MemW/address/writeData). Performs sub-word stores by read-modify-write and sub-word loads by lane extraction with sign/zero extension.
- Returns an LMD-ready 32-bit result plus a misalignment/illegal-size error flag.

Parameters:
- ADDR_W, 10, width of the memory word index; mem_addr = zero-extended req_addr[ADDR_W+1:2].

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle, can accept
- req_opcode  input  6  instruction opcode, forwarded to memory
- req_we  input  1  1=store, 0=load
- req_size  input  2  00=byte, 01=half, 10=word, 11=illegal
- req_signed  input  1  loads: 1=sign-extend, 0=zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result (0 for stores/errors)
- resp_err  output  1  misaligned or illegal size, valid with resp_valid
- mem_opcode  output  6  to data memory opcode
- mem_addr  output  32  to data memory address (word index)
- mem_wdata  output  32  to data memory writeData
- mem_MemR  output  1  to data memory MemR
- mem_MemW  output  1  to data memory MemW
- mem_rdata  input  32  from data memory readData

Behaviour:
- Handshake: accept on a rising edge with req_valid && req_ready. Latch opcode, we, size, signed, addr, wdata into internal registers; ignore request inputs until next IDLE.
- States: IDLE, RD, WR, DONE.
  - IDLE: req_ready=1.
  - Accept, error → DONE with err=1, no memory strobe.
  - Accept, load → RD.
  - Accept, word store → WR.
  - Accept, byte/half store → RD.
  - RD: mem_MemR=1; mem_rdata sampled at the edge ending RD.
    - Load → DONE; resp_rdata = extracted value.
    - Store → WR; merge register = sampled word with the store lanes replaced.
  - WR: mem_MemW=1; mem_wdata = merge register (sub-word) or latched wdata (word) → DONE.
  - DONE: resp_valid=1 for exactly one cycle → IDLE.
- Error rules: size 11; half with addr[0]=1; word with addr[1:0]≠0. Errors report resp_rdata=0.
- Lanes are little-endian:
  - Byte lane = addr[1:0], bits [8*k+7:8*k].
  - Half lane = addr[1], bits [16*h+15:16*h].
  - Byte store writes req_wdata[7:0]; half store writes req_wdata[15:0]. Other lanes are preserved from the RD sample.
- Extension: signed → replicate the top bit of the extracted field; unsigned → zero-fill.
- Latency (accept edge to resp_valid high):
  - Error: 1 cycle.
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Memory port:
  - mem_addr = {(32-ADDR_W)'b0, addr_q[ADDR_W+1:2]}; upper address bits are ignored, so addresses wrap modulo 4·2^ADDR_W.
  - mem_opcode = latched opcode.
  - mem_MemR and mem_MemW are decoded from state only; never both high. Both are 0 in IDLE and DONE.
- Reset: at a rising edge with rst=1, state→IDLE. Outputs after reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_MemR=0, mem_MemW=0, mem_addr=0, mem_wdata=0, mem_opcode=0.
  - Reset mid-RD/WR aborts; no response is produced.
  - A WR cycle already in progress at the reset edge may have completed its write; no further strobe occurs.
  - rst has priority over req_valid.
- resp_rdata and resp_err hold their value after DONE until the next DONE or reset.
- req_valid held high in DONE is not accepted until IDLE; back-to-back throughput is one request per latency+1 cycles.

Test Plan:
- Word load: mem[5]=32'hDEADBEEF; request load word addr=0x14 → MemR high one cycle with mem_addr=5; resp_valid 2 cycles after accept; resp_rdata=32'hDEADBEEF; resp_err=0.
- Signed/unsigned byte load: mem[2]=32'h80FF7F01; load byte addr=0x0A signed → 32'hFFFFFFFF; unsigned addr=0x0B → 32'h00000080; signed addr=0x09 → 32'h0000007F.
- Half store RMW: mem[3]=32'h11223344; store half addr=0x0E wdata=32'hAAAABEEF → MemR then MemW on mem_addr=3; mem[3]=32'hBEEF3344; resp_valid 3 cycles after accept.
- Byte store then word load: store byte addr=0x01 wdata=0x5A over mem[0]=0 → mem[0]=32'h00005A00; a following word load of addr=0 returns 32'h00005A00.
- Errors: word load addr=0x06, half store addr=0x03, size=11 → each resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept; MemR and MemW never asserted; memory unchanged.
- Reset mid-op: assert rst during RD of a byte store → next cycle IDLE with req_ready=1; MemW never asserted; target word unchanged; no resp_valid.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: request/response handshake plus word-indexed data memory port of the load/store unit.
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [5:0]  mem_opcode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_MemR;
    logic        mem_MemW;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_opcode, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_opcode, mem_addr, mem_wdata, mem_MemR, mem_MemW
    );
    modport master (
        output req_valid, req_opcode, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_opcode, mem_addr, mem_wdata, mem_MemR, mem_MemW
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front-end; sub-word stores by read-modify-write,
// sub-word loads by lane extraction with sign/zero extension.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t              state, next;
    logic [5:0]          opcode_q;
    logic                we_q, signed_q, err_q;
    logic [1:0]          size_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         merge_q, rdata_q;
    logic                bad;
    logic [4:0]          sh;
    logic [31:0]         mask, ext;
    logic [7:0]          b;
    logic [15:0]         h;
    assign bad = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    assign sh   = size_q == 2'b00 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    assign mask = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign b    = 8'(bus.mem_rdata >> sh);
    assign h    = 16'(bus.mem_rdata >> sh);
    assign ext  = size_q == 2'b10 ? bus.mem_rdata :
                  size_q == 2'b00 ? {{24{signed_q & b[7]}}, b} : {{16{signed_q & h[15]}}, h};
    always_comb begin
        next = state;
        case (state)
            IDLE: next = !bus.req_valid ? IDLE : bad ? DONE :
                         (bus.req_we && bus.req_size == 2'b10) ? WR : RD;
            RD:   next = we_q ? WR : DONE;
            WR:   next = DONE;
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end
    // merge_q carries the store data until RD folds it into the sampled word
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opcode_q <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && bus.req_valid) begin
                opcode_q <= bus.req_opcode;
                we_q     <= bus.req_we;
                signed_q <= bus.req_signed;
                size_q   <= bus.req_size;
                addr_q   <= bus.req_addr[ADDR_W+1:0];
                merge_q  <= bus.req_wdata;
                if (bad) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
            if (state == RD && we_q)
                merge_q <= (bus.mem_rdata & ~mask) | ((merge_q << sh) & mask);
            if (state == RD && !we_q) begin
                rdata_q <= ext;
                err_q   <= 1'b0;
            end
            if (state == WR) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end
    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == DONE;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_opcode = opcode_q;
    assign bus.mem_addr   = 32'(addr_q[ADDR_W+1:2]);
    assign bus.mem_MemR   = state == RD;
    assign bus.mem_MemW   = state == WR;
    assign bus.mem_wdata  = state == WR ? merge_q : 32'h0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random requests checked against a byte-array reference memory.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_access_if bus();
    mem_access_unit #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    logic [31:0] mem [1024];
    logic [7:0]  ref_b [4096];
    int checks = 0;
    int failures = 0;
    assign bus.mem_rdata = mem[bus.mem_addr[9:0]];
    always @(posedge clk) if (bus.mem_MemW) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    task automatic set_word(input int idx, input logic [31:0] v);
        mem[idx] = v;
        for (int i = 0; i < 4; i++) ref_b[4*idx+i] = v[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n, input bit sgn);
        logic [63:0] v = 0;
        int a = int'(addr % 4096);
        for (int i = 0; i < n; i++) v = v | (64'(ref_b[a+i]) << (8*i));
        if (sgn && v[8*n-1]) v = v | (~64'h0 << (8*n));
        return v[31:0];
    endfunction

    task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] rd);
        int n = 1 << size;
        bit e = size == 2'b11 || (addr % n) != 0;
        int idx = int'((addr % 4096) / 4);
        logic [31:0] er = (e || we) ? 32'h0 : ref_load(addr, n, sgn);
        int el = e ? 1 : (we && size != 2'b10) ? 3 : 2;
        int enr = (!e && (!we || size != 2'b10)) ? 1 : 0;
        int enw = (!e && we) ? 1 : 0;
        int lat = 0, nr = 0, nw = 0;
        logic [5:0] op = 6'($urandom);
        chk("ready_before", 32'(bus.req_ready), 1);
        bus.req_valid = 1; bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_opcode = op;
        @(posedge clk);
        #1;
        bus.req_valid = 0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
        bus.req_size = 2'($urandom); bus.req_we = 1'($urandom); bus.req_opcode = 6'($urandom);
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            chk("strobe_excl", 32'(bus.mem_MemR & bus.mem_MemW), 0);
            if (bus.mem_MemR || bus.mem_MemW) begin
                chk("mem_addr", bus.mem_addr, 32'(idx));
                chk("mem_opcode", 32'(bus.mem_opcode), 32'(op));
            end
            nr += int'(bus.mem_MemR);
            nw += int'(bus.mem_MemW);
            if (bus.resp_valid) break;
        end
        chk("latency", lat, el);
        chk("memr_count", nr, enr);
        chk("memw_count", nw, enw);
        chk("resp_rdata", bus.resp_rdata, er);
        chk("resp_err", 32'(bus.resp_err), 32'(e));
        if (!e && we) for (int i = 0; i < n; i++) ref_b[int'(addr % 4096) + i] = wdata[8*i +: 8];
        rd = bus.resp_rdata;
        @(negedge clk);
        chk("resp_pulse", 32'(bus.resp_valid), 0);
        chk("resp_hold", bus.resp_rdata, er);
        chk("mem_word", mem[idx], ref_word(idx));
    endtask

    initial begin
        logic [31:0] r;
        bit sawv;
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_signed = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.req_opcode = 0;
        for (int i = 0; i < 1024; i++) set_word(i, $urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_valid", 32'(bus.resp_valid), 0);
        chk("rst_err", 32'(bus.resp_err), 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_memr", 32'(bus.mem_MemR), 0);
        chk("rst_memw", 32'(bus.mem_MemW), 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_opcode", 32'(bus.mem_opcode), 0);
        set_word(5, 32'hDEADBEEF);
        do_req(0, 2'b10, 0, 32'h14, 0, r);
        chk("tp_word_load", r, 32'hDEADBEEF);
        set_word(2, 32'h80FF7F01);
        do_req(0, 2'b00, 1, 32'h0A, 0, r);
        chk("tp_lb_signed", r, 32'hFFFFFFFF);
        do_req(0, 2'b00, 0, 32'h0B, 0, r);
        chk("tp_lbu", r, 32'h00000080);
        do_req(0, 2'b00, 1, 32'h09, 0, r);
        chk("tp_lb_pos", r, 32'h0000007F);
        set_word(3, 32'h11223344);
        do_req(1, 2'b01, 0, 32'h0E, 32'hAAAABEEF, r);
        chk("tp_sh_rmw", mem[3], 32'hBEEF3344);
        set_word(0, 0);
        do_req(1, 2'b00, 0, 32'h01, 32'h5A, r);
        do_req(0, 2'b10, 0, 32'h00, 0, r);
        chk("tp_sb_lw", r, 32'h00005A00);
        do_req(0, 2'b10, 0, 32'h06, 0, r);
        do_req(1, 2'b01, 0, 32'h03, 32'h1234, r);
        do_req(0, 2'b11, 0, 32'h10, 0, r);
        do_req(0, 2'b01, 1, 32'hFFFF_F002, 0, r);
        // reset lands while a byte store is in its read phase
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 0; bus.req_addr = 32'h21; bus.req_wdata = 32'hC3;
        @(posedge clk);
        #1 bus.req_valid = 0;
        @(negedge clk);
        chk("abort_in_rd", 32'(bus.mem_MemR), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_ready", 32'(bus.req_ready), 1);
        chk("abort_rdata", bus.resp_rdata, 0);
        sawv = 0;
        repeat (4) begin
            sawv |= bus.mem_MemW | bus.resp_valid | bus.mem_MemR;
            @(negedge clk);
        end
        chk("abort_quiet", 32'(sawv), 0);
        chk("abort_mem", mem[8], ref_word(8));
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a = $urandom & 32'hFFFF_F03F;
            logic [1:0] sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'h1 << sz) - 1);
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, r);
        end
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_word(i)) begin
                chk("final_mem", mem[i], ref_word(i));
                break;
            end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
